// File: rtl/boot_pkg.sv
// Shared types and frame constants for the UART boot loader.
// Parser/sampler state encodings and field widths live here.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_H,
    LEN_L,
    DATA,
    CHK,
    DONE
  } boot_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;
  localparam int BPW    = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling, framing check.
// Emits one-cycle rx_valid or rx_ferr per received character.
module uart_rx_sampler
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t state;
  rx_state_t state_n;

  logic [2:0]    sync_q;
  logic          rx;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          half;
  logic          full;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value
  assign rx   = sync_q[1];
  assign prev = sync_q[2];
  assign half = (cnt == HALF);
  assign full = (cnt == FULL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RX_IDLE: begin
        if (prev && !rx) state_n = RX_START;
      end
      RX_START: begin
        if (half) state_n = rx ? RX_IDLE : RX_BITS;
      end
      RX_BITS: begin
        if (full && bit_idx == 3'd7) state_n = RX_STOP;
      end
      RX_STOP: begin
        if (full) state_n = rx ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: begin
        if (rx) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= 3'b111;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], uart_rx};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (state_n != state || (state == RX_BITS && full)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == RX_BITS && full) begin
        sh      <= {rx, sh[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == RX_STOP && full) begin
        if (rx) begin
          rx_valid <= 1'b1;
          rx_byte  <= sh;
        end else begin
          rx_ferr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: parses SYNC/LEN/words/CHK frames from UART into imem
// and releases the core from reset once the checksum matches.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADDR_WIDTH   = 14,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [WORD_W-1:0]     imem_wr_data,
  output logic                  core_reset,
  output logic                  boot_done,
  output logic                  boot_error
);

  localparam int CW =
    (ADDR_WIDTH + 1 > LEN_W) ? ADDR_WIDTH + 1 : LEN_W;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  boot_state_t state;
  boot_state_t state_n;

  logic [7:0]          len_hi;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    nlen;
  logic [ADDR_WIDTH:0] wcnt;
  logic [23:0]         word;
  logic [1:0]          bcnt;
  logic [7:0]          csum;
  logic                too_long;
  logic                last_word;
  logic                abort;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock   (clock),
    .reset   (reset),
    .uart_rx (uart_rx),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_ferr (rx_ferr)
  );

  // Word counts are compared in a width that holds both LEN and 2^AW
  assign nlen      = {len_hi, rx_byte};
  assign too_long  = CW'(nlen) > (CW'(1) << ADDR_WIDTH);
  assign last_word = (CW'(wcnt) + CW'(1)) == CW'(len);
  assign abort     = rx_ferr && state != DONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_byte == SYNC_BYTE) state_n = LEN_H;
        end
        LEN_H: state_n = LEN_L;
        LEN_L: begin
          if (too_long)          state_n = IDLE;
          else if (nlen == '0)   state_n = CHK;
          else                   state_n = DATA;
        end
        DATA: begin
          if (bcnt == 2'd3 && last_word) state_n = CHK;
        end
        CHK: begin
          state_n = (rx_byte == csum) ? DONE : IDLE;
        end
        DONE: state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      core_reset   <= 1'b1;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
      len_hi       <= '0;
      len          <= '0;
      wcnt         <= '0;
      word         <= '0;
      bcnt         <= '0;
      csum         <= '0;
    end else begin
      imem_wr_en <= 1'b0;
      if (abort) begin
        boot_error <= 1'b1;
      end else if (rx_valid) begin
        unique case (state)
          IDLE: begin
            if (rx_byte == SYNC_BYTE) begin
              boot_error <= 1'b0;
              csum       <= '0;
            end
          end
          LEN_H: len_hi <= rx_byte;
          LEN_L: begin
            len  <= nlen;
            wcnt <= '0;
            bcnt <= '0;
            if (too_long) boot_error <= 1'b1;
          end
          DATA: begin
            word <= {rx_byte, word[23:8]};
            csum <= csum ^ rx_byte;
            bcnt <= bcnt + 1'b1;
            // Little-endian: first byte of the word ends in bits 7:0
            if (bcnt == 2'd3) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= wcnt[ADDR_WIDTH-1:0];
              imem_wr_data <= {rx_byte, word};
              wcnt         <= wcnt + 1'b1;
            end
          end
          CHK: begin
            if (rx_byte == csum) begin
              boot_done  <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              boot_error <= 1'b1;
            end
          end
          DONE: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader at 16 clocks/bit, 16-word imem.
// Drives UART frames and checks writes, flags and core_reset timing.
module tb_uart_boot_loader;
  import boot_pkg::*;

  localparam int CPB = 16;
  localparam int AW  = 4;

  logic          clock;
  logic          reset;
  logic          rxl;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic          core_reset;
  logic          boot_done;
  logic          boot_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int last_v = 0;
  int cr_cyc = 0;
  bit cr_seen = 0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [7:0]    tx[$];

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_rx     (rxl),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .core_reset  (core_reset),
    .boot_done   (boot_done),
    .boot_error  (boot_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_wr_en) begin
      wa.push_back(imem_wr_addr);
      wd.push_back(imem_wr_data);
    end
    if (dut.rx_valid) begin
      nvalid++;
      if (!cr_seen) last_v = cyc;
    end
    if (!core_reset && !cr_seen) begin
      cr_seen = 1'b1;
      cr_cyc  = cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop = 1'b1);
    rxl = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxl = b[i];
      repeat (CPB) @(negedge clock);
    end
    rxl = stop;
    repeat (CPB) @(negedge clock);
    rxl = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_tx();
    foreach (tx[i]) send_byte(tx[i]);
    repeat (20) @(negedge clock);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    cr_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    clear_log();
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, "_wr_en"}, 32'(imem_wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(imem_wr_addr), 32'd0);
    check({tag, "_wr_data"}, imem_wr_data, 32'd0);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_boot_done"}, 32'(boot_done), 32'd0);
    check({tag, "_boot_error"}, 32'(boot_error), 32'd0);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    rxl   = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_rst_vals("rst");
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // Good two-word frame; checksum 0x66 is the xor of the data bytes
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h02,
           8'h44, 8'h33, 8'h22, 8'h11,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
    send_tx();
    check("t1_nwr", wa.size(), 32'd2);
    check("t1_a0", 32'(wa[0]), 32'd0);
    check("t1_d0", wd[0], 32'h11223344);
    check("t1_a1", 32'(wa[1]), 32'd1);
    check("t1_d1", wd[1], 32'hDEADBEEF);
    check("t1_done", 32'(boot_done), 32'd1);
    check("t1_err", 32'(boot_error), 32'd0);
    check("t1_core_rst", 32'(core_reset), 32'd0);
    check("t1_cr_lat", 32'(cr_cyc - last_v), 32'd1);

    // Bad checksum, then resend the good frame
    do_reset();
    tx[11] = 8'h23;
    send_tx();
    check("t2_nwr", wa.size(), 32'd2);
    check("t2_err", 32'(boot_error), 32'd1);
    check("t2_core_rst", 32'(core_reset), 32'd1);
    check("t2_done", 32'(boot_done), 32'd0);
    check("t2_state", 32'(dut.state), 32'(IDLE));
    send_byte(8'hA5);
    check("t2_err_clr", 32'(boot_error), 32'd0);
    tx.delete(0);
    tx[10] = 8'h66;
    send_tx();
    check("t2_done2", 32'(boot_done), 32'd1);
    check("t2_nwr2", wa.size(), 32'd4);
    check("t2_a2", 32'(wa[2]), 32'd0);
    check("t2_d3", wd[3], 32'hDEADBEEF);

    // Leading junk, empty image
    do_reset();
    tx = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_tx();
    check("t3_nwr", wa.size(), 32'd0);
    check("t3_done", 32'(boot_done), 32'd1);
    check("t3_core_rst", 32'(core_reset), 32'd0);

    // Length 17 exceeds 16-word memory
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h11};
    send_tx();
    check("t4_err", 32'(boot_error), 32'd1);
    check("t4_nwr", wa.size(), 32'd0);
    check("t4_state", 32'(dut.state), 32'(IDLE));

    // Framing error in the second word, then a start-bit glitch
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h02,
           8'h44, 8'h33, 8'h22, 8'h11, 8'hEF};
    send_tx();
    send_byte(8'hBE, 1'b0);
    repeat (20) @(negedge clock);
    check("t5_err", 32'(boot_error), 32'd1);
    check("t5_nwr", wa.size(), 32'd1);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    n0  = nvalid;
    rxl = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    rxl = 1'b1;
    repeat (4 * CPB) @(negedge clock);
    check("t5_glitch", 32'(nvalid - n0), 32'd0);
    tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_tx();
    check("t5_rearm", 32'(boot_done), 32'd1);
    check("t5_err_clr", 32'(boot_error), 32'd0);

    // Reset mid-DATA, then boot a different image
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h02,
           8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE};
    send_tx();
    check("t6_pre_nwr", wa.size(), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_rst_vals("t6");
    clear_log();
    tx = '{8'hA5, 8'h00, 8'h02,
           8'h0D, 8'hF0, 8'hFE, 8'hCA,
           8'h04, 8'h03, 8'h02, 8'h01, 8'hCD};
    send_tx();
    check("t6_nwr", wa.size(), 32'd2);
    check("t6_a0", 32'(wa[0]), 32'd0);
    check("t6_d0", wd[0], 32'hCAFEF00D);
    check("t6_d1", wd[1], 32'h01020304);
    check("t6_done", 32'(boot_done), 32'd1);

    // Full 16-word image; each word's bytes cancel so CHK is 0
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h10};
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 4; k++) tx.push_back(8'(w));
    tx.push_back(8'h00);
    send_tx();
    check("t7_nwr", wa.size(), 32'd16);
    check("t7_a15", 32'(wa[15]), 32'd15);
    check("t7_d15", wd[15], 32'h0F0F0F0F);
    check("t7_d3", wd[3], 32'h03030303);
    check("t7_done", 32'(boot_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
